// File: rtl/cpu_ctrl_pkg.sv
// Shared control-flow definitions for the EX-stage branch resolution logic.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_BEQ  = 3'b001,
    BR_BNE  = 3'b010,
    BR_BLEZ = 3'b011,
    BR_BGTZ = 3'b100,
    BR_BLTZ = 3'b101,
    BR_J    = 3'b110,
    BR_JR   = 3'b111
  } br_op_t;

  localparam int GAP_SHIFT_DEF = 2;
  localparam int FCNT_W        = 4;

endpackage

// File: rtl/branch_target_calc.sv
// Combinational branch/jump target, taken decision and JR alignment check.
module branch_target_calc
  import cpu_ctrl_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int IMM_W     = 16,
  parameter int JIDX_W    = 26,
  parameter int GAP_SHIFT = GAP_SHIFT_DEF
) (
  input  logic [2:0]        i_op,
  input  logic [ADDR_W-1:0] i_pc_next,
  input  logic [IMM_W-1:0]  i_imm,
  input  logic [JIDX_W-1:0] i_jidx,
  input  logic [ADDR_W-1:0] i_rs_val,
  input  logic [ADDR_W-1:0] i_rt_val,
  output logic [ADDR_W-1:0] o_target,
  output logic              o_taken,
  output logic              o_misalign
);

  br_op_t            w_op;
  logic [ADDR_W-1:0] w_imm_ext;
  logic [ADDR_W-1:0] w_br_target;
  logic [ADDR_W-1:0] w_j_target;
  logic              w_rs_zero;
  logic              w_rs_neg;

  assign w_op        = br_op_t'(i_op);
  assign w_imm_ext   = {{(ADDR_W-IMM_W){i_imm[IMM_W-1]}}, i_imm};
  assign w_br_target = i_pc_next + (w_imm_ext << GAP_SHIFT);
  assign w_rs_zero   = ~|i_rs_val;
  assign w_rs_neg    = i_rs_val[ADDR_W-1];

  // When the jump index fills the whole PC above the gap there are no PC bits to keep.
  generate
    if (JIDX_W + GAP_SHIFT < ADDR_W) begin : g_jkeep
      assign w_j_target = {i_pc_next[ADDR_W-1:JIDX_W+GAP_SHIFT], i_jidx, {GAP_SHIFT{1'b0}}};
    end else begin : g_jfull
      assign w_j_target = {i_jidx, {GAP_SHIFT{1'b0}}};
    end
  endgenerate

  always_comb begin
    o_target   = w_br_target;
    o_taken    = 1'b0;
    o_misalign = 1'b0;
    case (w_op)
      BR_BEQ:  o_taken = (i_rs_val == i_rt_val);
      BR_BNE:  o_taken = (i_rs_val != i_rt_val);
      BR_BLEZ: o_taken = w_rs_neg | w_rs_zero;
      BR_BGTZ: o_taken = ~w_rs_neg & ~w_rs_zero;
      BR_BLTZ: o_taken = w_rs_neg;
      BR_J: begin
        o_taken  = 1'b1;
        o_target = w_j_target;
      end
      BR_JR: begin
        o_taken    = 1'b1;
        o_target   = i_rs_val;
        o_misalign = |i_rs_val[GAP_SHIFT-1:0];
      end
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: registered redirect plus a counted wrong-path flush window.
module branch_resolve_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int IMM_W        = 16,
  parameter int GAP_SHIFT    = GAP_SHIFT_DEF,
  parameter int JIDX_W       = 26,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [2:0]        in_op,
  input  logic [ADDR_W-1:0] pc_next,
  input  logic [IMM_W-1:0]  imm,
  input  logic [JIDX_W-1:0] jidx,
  input  logic [ADDR_W-1:0] rs_val,
  input  logic [ADDR_W-1:0] rt_val,
  input  logic              stall,
  output logic              out_valid,
  output logic              out_taken,
  output logic              redirect,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              misalign,
  output logic              flush
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;
  localparam logic [FCNT_W-1:0] FCNT_LOAD = FCNT_W'(FLUSH_CYCLES);

  logic [0:0]        r_state;
  logic [FCNT_W-1:0] r_flush_cnt;
  logic              r_valid;
  logic              r_taken;
  logic              r_redirect;
  logic [ADDR_W-1:0] r_pc;
  logic              r_misalign;
  logic              r_flush;

  logic [ADDR_W-1:0] w_target;
  logic              w_taken;
  logic              w_misalign;

  branch_target_calc #(
    .ADDR_W   (ADDR_W),
    .IMM_W    (IMM_W),
    .JIDX_W   (JIDX_W),
    .GAP_SHIFT(GAP_SHIFT)
  ) u_calc (
    .i_op      (in_op),
    .i_pc_next (pc_next),
    .i_imm     (imm),
    .i_jidx    (jidx),
    .i_rs_val  (rs_val),
    .i_rt_val  (rt_val),
    .o_target  (w_target),
    .o_taken   (w_taken),
    .o_misalign(w_misalign)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_flush_cnt <= '0;
      r_valid     <= 1'b0;
      r_taken     <= 1'b0;
      r_redirect  <= 1'b0;
      r_pc        <= '0;
      r_misalign  <= 1'b0;
      r_flush     <= 1'b0;
    end else if (!stall) begin
      if (r_state == ST_RUN) begin
        r_valid    <= in_valid;
        r_taken    <= in_valid & w_taken;
        r_redirect <= in_valid & w_taken;
        if (in_valid && w_taken) begin
          r_pc        <= w_target;
          r_misalign  <= w_misalign;
          r_flush_cnt <= FCNT_LOAD;
          r_flush     <= 1'b1;
          r_state     <= ST_FLUSH;
        end
      end else begin
        r_valid     <= 1'b0;
        r_taken     <= 1'b0;
        r_redirect  <= 1'b0;
        r_flush_cnt <= r_flush_cnt - 1'b1;
        // Count hits zero on this edge: the next presented instruction is accepted.
        if (r_flush_cnt == FCNT_W'(1)) begin
          r_flush <= 1'b0;
          r_state <= ST_RUN;
        end
      end
    end
  end

  assign out_valid   = r_valid;
  assign out_taken   = r_taken;
  assign redirect    = r_redirect;
  assign redirect_pc = r_pc;
  assign misalign    = r_misalign;
  assign flush       = r_flush;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: spec-level model feeds a queue, monitor compares.
module tb_branch_resolve_unit;

  localparam int FLUSH_N = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [2:0]  in_op = 3'b000;
  logic [31:0] pc_next = '0;
  logic [15:0] imm = '0;
  logic [25:0] jidx = '0;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        stall = 1'b0;
  logic        out_valid, out_taken, redirect, misalign, flush;
  logic [31:0] redirect_pc;

  branch_resolve_unit #(
    .ADDR_W(32), .IMM_W(16), .GAP_SHIFT(2), .JIDX_W(26), .FLUSH_CYCLES(FLUSH_N)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_op(in_op), .pc_next(pc_next),
    .imm(imm), .jidx(jidx), .rs_val(rs_val), .rt_val(rt_val), .stall(stall),
    .out_valid(out_valid), .out_taken(out_taken), .redirect(redirect),
    .redirect_pc(redirect_pc), .misalign(misalign), .flush(flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v, t, r, m, f;
    logic [31:0] pc;
  } exp_t;

  exp_t q[$];
  exp_t prev;
  int   squash_left;
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic m_taken(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    case (op)
      3'd1: return rs == rt;
      3'd2: return rs != rt;
      3'd3: return $signed(rs) <= 0;
      3'd4: return $signed(rs) > 0;
      3'd5: return $signed(rs) < 0;
      3'd6, 3'd7: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_target(input logic [2:0] op, input logic [31:0] pcn,
                                           input logic [15:0] im, input logic [25:0] ji,
                                           input logic [31:0] rs);
    longint off;
    off = longint'($signed(im)) * 4;
    case (op)
      3'd6: return (pcn & 32'hF000_0000) | (32'(ji) * 32'd4);
      3'd7: return rs;
      default: return 32'(longint'(pcn) + off);
    endcase
  endfunction

  function automatic void model_reset();
    prev = '{v: 1'b0, t: 1'b0, r: 1'b0, m: 1'b0, f: 1'b0, pc: 32'h0};
    squash_left = 0;
  endfunction

  // Apply one cycle of inputs, predict the registered response, push it at the edge.
  task automatic cyc(input logic iv, input logic [2:0] op, input logic [31:0] pcn,
                     input logic [15:0] im, input logic [25:0] ji, input logic [31:0] rs,
                     input logic [31:0] rt, input logic st);
    exp_t e;
    in_valid = iv; in_op = op; pc_next = pcn; imm = im; jidx = ji;
    rs_val = rs; rt_val = rt; stall = st;
    e = prev;
    if (!st) begin
      if (squash_left > 0) begin
        squash_left--;
        e.v = 0; e.t = 0; e.r = 0;
        e.f = (squash_left > 0);
      end else begin
        e.v = iv;
        e.t = iv && m_taken(op, rs, rt);
        e.r = e.t;
        e.f = 0;
        if (e.t) begin
          e.pc = m_target(op, pcn, im, ji, rs);
          e.m  = (op == 3'd7) && (rs % 4 != 0);
          e.f  = 1;
          squash_left = FLUSH_N;
        end
      end
    end
    prev = e;
    @(posedge clk);
    q.push_back(e);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 3'd0, '0, '0, '0, '0, '0, 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " out_valid"}, 32'(out_valid), 0);
    chk({tag, " out_taken"}, 32'(out_taken), 0);
    chk({tag, " redirect"}, 32'(redirect), 0);
    chk({tag, " redirect_pc"}, redirect_pc, 0);
    chk({tag, " misalign"}, 32'(misalign), 0);
    chk({tag, " flush"}, 32'(flush), 0);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("out_valid", 32'(out_valid), 32'(e.v));
      if (e.v) chk("out_taken", 32'(out_taken), 32'(e.t));
      chk("redirect", 32'(redirect), 32'(e.r));
      chk("redirect_pc", redirect_pc, e.pc);
      if (e.r) chk("misalign", 32'(misalign), 32'(e.m));
      chk("flush", 32'(flush), 32'(e.f));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r1, r2;
    logic [2:0]  op;
    model_reset();
    #23;
    check_zero("reset");
    @(negedge clk); #2; rst = 1'b0;

    // BEQ taken, backward offset
    cyc(1, 3'd1, 32'h0000_0104, 16'hFFFE, '0, 32'd5, 32'd5, 0);
    idle(3);
    // BNE not taken, then BLTZ taken
    cyc(1, 3'd2, 32'h0000_0200, 16'h0010, '0, 32'd7, 32'd7, 0);
    cyc(1, 3'd5, 32'h0000_0300, 16'h0003, '0, 32'hFFFF_FFFF, 32'd0, 0);
    idle(3);
    // J and wrap-around BGTZ
    cyc(1, 3'd6, 32'h4000_0008, 16'h0000, 26'h0000010, '0, '0, 0);
    idle(3);
    cyc(1, 3'd4, 32'hFFFF_FFFC, 16'h0002, '0, 32'd1, 32'd0, 0);
    idle(3);
    // Squash: two in-window taken branches, third accepted
    cyc(1, 3'd1, 32'h0000_1000, 16'h0004, '0, 32'd9, 32'd9, 0);
    cyc(1, 3'd2, 32'h0000_2000, 16'h0004, '0, 32'd1, 32'd2, 0);
    cyc(1, 3'd2, 32'h0000_3000, 16'h0004, '0, 32'd1, 32'd2, 0);
    cyc(1, 3'd1, 32'h0000_4000, 16'h0008, '0, 32'd3, 32'd3, 0);
    idle(3);
    // Stall right after a redirect
    cyc(1, 3'd1, 32'h0000_5000, 16'h0001, '0, 32'd0, 32'd0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 3'd6, 32'h1234_5678, '0, 26'h3FFFFFF, '0, '0, 1);
    idle(4);
    // Misaligned JR, then reset mid-flush
    cyc(1, 3'd7, 32'h0000_0010, '0, '0, 32'h0000_1002, '0, 0);
    @(negedge clk); #1;
    rst = 1'b1; #1;
    check_zero("rst_mid_flush");
    model_reset();
    #1; rst = 1'b0;
    cyc(1, 3'd7, 32'h0000_0020, '0, '0, 32'h0000_2000, '0, 0);
    idle(3);
    cyc(1, 3'd0, 32'h0000_0040, 16'h0005, '0, '0, '0, 0);

    for (int n = 0; n < 3000; n++) begin
      r1 = $urandom;
      case ($urandom_range(0, 3))
        0: r1 = 32'd0;
        1: r1 = {{16{r1[15]}}, r1[15:0]};
        default: ;
      endcase
      r2 = ($urandom_range(0, 1) == 1) ? r1 : $urandom;
      op = 3'($urandom_range(0, 7));
      cyc($urandom_range(0, 9) < 8, op, $urandom, 16'($urandom), 26'($urandom), r1, r2,
          $urandom_range(0, 9) < 2);
    end
    idle(2);

    @(negedge clk); #1;
    chk("queue_drained", 32'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
